// File: rtl/deca_gpio_pkg.sv
// Shared constants for the deca_gpio_pio Avalon-MM GPIO peripheral:
// bus data width and register word offsets.
package deca_gpio_pkg;

    localparam int DATA_W = 32;

    localparam logic [2:0] REG_DATA_IN  = 3'd0;
    localparam logic [2:0] REG_DATA_OUT = 3'd1;
    localparam logic [2:0] REG_IRQ_MASK = 3'd2;
    localparam logic [2:0] REG_EDGE_CAP = 3'd3;
    localparam logic [2:0] REG_RISE_EN  = 3'd4;
    localparam logic [2:0] REG_FALL_EN  = 3'd5;
    localparam logic [2:0] REG_OUT_SET  = 3'd6;
    localparam logic [2:0] REG_OUT_CLR  = 3'd7;

endpackage

// File: rtl/deca_debounce.sv
// One input channel: synchroniser, polarity correction and debounce filter.
// Reports the debounced level plus single-cycle rise/fall strobes.
module deca_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic pin,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt;
    logic                   s;
    logic                   stable_next;

    // Synchroniser flops idle at the pin's inactive level so reset reads as "not pressed".
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {SYNC_STAGES{ACTIVE_LOW}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin};
        end
    end

    assign s = sync_q[SYNC_STAGES-1] ^ ACTIVE_LOW;

    always_comb begin
        stable_next = stable;
        if ((s != stable) && (cnt == CNT_LAST)) begin
            stable_next = s;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            stable <= stable_next;
            if ((s == stable) || (cnt == CNT_LAST)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign rise = stable_next & ~stable;
    assign fall = ~stable_next & stable;

endmodule

// File: rtl/deca_gpio_pio.sv
// Avalon-MM GPIO peripheral: debounced inputs with edge capture and a maskable
// level interrupt, plus polarity-corrected outputs with set/clear access.
module deca_gpio_pio
    import deca_gpio_pkg::*;
#(
    parameter int IN_WIDTH        = 8,
    parameter int OUT_WIDTH       = 8,
    parameter int IN_ACTIVE_LOW   = 1,
    parameter int OUT_ACTIVE_LOW  = 1,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [2:0]           avs_address,
    input  logic                 avs_read,
    input  logic                 avs_write,
    input  logic [DATA_W-1:0]    avs_writedata,
    output logic [DATA_W-1:0]    avs_readdata,
    output logic                 irq,
    input  logic [IN_WIDTH-1:0]  pio_in,
    output logic [OUT_WIDTH-1:0] pio_out
);

    if (IN_WIDTH < 1 || IN_WIDTH > 32) begin : g_bad_in_width
        $error("deca_gpio_pio: IN_WIDTH must be in 1..32");
    end
    if (OUT_WIDTH < 1 || OUT_WIDTH > 32) begin : g_bad_out_width
        $error("deca_gpio_pio: OUT_WIDTH must be in 1..32");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("deca_gpio_pio: SYNC_STAGES must be >= 2");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("deca_gpio_pio: DEBOUNCE_CYCLES must be >= 1");
    end

    localparam bit IN_POL  = (IN_ACTIVE_LOW != 0);
    localparam bit OUT_POL = (OUT_ACTIVE_LOW != 0);

    logic [IN_WIDTH-1:0]  stable, rise, fall;
    logic [IN_WIDTH-1:0]  irq_mask, edge_cap, rise_en, fall_en;
    logic [IN_WIDTH-1:0]  wdata_in, cap_set, cap_clr;
    logic [OUT_WIDTH-1:0] data_out, wdata_out;
    logic [DATA_W-1:0]    rd_mux;
    logic                 unused_wdata;

    for (genvar i = 0; i < IN_WIDTH; i++) begin : g_ch
        deca_debounce #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (IN_POL)
        ) u_debounce (
            .clk     (clk),
            .reset_n (reset_n),
            .pin     (pio_in[i]),
            .stable  (stable[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    // Bits above the channel count are simply dropped.
    assign wdata_in     = avs_writedata[IN_WIDTH-1:0];
    assign wdata_out    = avs_writedata[OUT_WIDTH-1:0];
    assign unused_wdata = ^avs_writedata;

    assign cap_set = (rise & rise_en) | (fall & fall_en);
    assign cap_clr = (avs_write && (avs_address == REG_EDGE_CAP)) ? wdata_in : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_out <= '0;
            irq_mask <= '0;
            rise_en  <= '0;
            fall_en  <= '0;
        end else if (avs_write) begin
            case (avs_address)
                REG_DATA_OUT: data_out <= wdata_out;
                REG_IRQ_MASK: irq_mask <= wdata_in;
                REG_RISE_EN:  rise_en  <= wdata_in;
                REG_FALL_EN:  fall_en  <= wdata_in;
                REG_OUT_SET:  data_out <= data_out | wdata_out;
                REG_OUT_CLR:  data_out <= data_out & ~wdata_out;
                default: ;
            endcase
        end
    end

    // Applying the clear before the set lets a fresh edge survive a simultaneous W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cap <= '0;
            irq      <= 1'b0;
        end else begin
            edge_cap <= (edge_cap & ~cap_clr) | cap_set;
            irq      <= |(edge_cap & irq_mask);
        end
    end

    always_comb begin
        rd_mux = '0;
        case (avs_address)
            REG_DATA_IN:  rd_mux[IN_WIDTH-1:0]  = stable;
            REG_DATA_OUT: rd_mux[OUT_WIDTH-1:0] = data_out;
            REG_IRQ_MASK: rd_mux[IN_WIDTH-1:0]  = irq_mask;
            REG_EDGE_CAP: rd_mux[IN_WIDTH-1:0]  = edge_cap;
            REG_RISE_EN:  rd_mux[IN_WIDTH-1:0]  = rise_en;
            REG_FALL_EN:  rd_mux[IN_WIDTH-1:0]  = fall_en;
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_mux;
        end
    end

    assign pio_out = data_out ^ {OUT_WIDTH{OUT_POL}};

endmodule

// File: tb/tb_deca_gpio_pio.sv
// Bench for deca_gpio_pio: a sliding-window debounce model and register model
// checked every cycle, plus directed scenarios with literal expectations.
module tb_deca_gpio_pio;
    import deca_gpio_pkg::*;

    localparam int SYNC = 2;
    localparam int DB   = 4;
    localparam int HIST = SYNC + DB;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [2:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;
    logic        irq;
    logic [7:0]  pio_in;
    logic [7:0]  pio_out;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 1'b0;

    deca_gpio_pio #(
        .IN_WIDTH        (8),
        .OUT_WIDTH       (8),
        .IN_ACTIVE_LOW   (1),
        .OUT_ACTIVE_LOW  (1),
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .avs_address   (avs_address),
        .avs_read      (avs_read),
        .avs_write     (avs_write),
        .avs_writedata (avs_writedata),
        .avs_readdata  (avs_readdata),
        .irq           (irq),
        .pio_in        (pio_in),
        .pio_out       (pio_out)
    );

    always #5 clk = ~clk;

    // Model: pin_q[k] holds the raw pins sampled k+1 edges ago. A channel flips
    // once its last DB synchronised logical samples all disagree with it.
    logic [7:0]  pin_q [HIST];
    logic [7:0]  m_stable, m_data_out, m_mask, m_cap, m_rise_en, m_fall_en;
    logic [7:0]  m_flip, m_stable_nxt, m_cap_set, m_cap_clr;
    logic        m_irq;
    logic [31:0] m_rdata;

    always_comb begin
        m_flip = 8'hFF;
        for (int ch = 0; ch < 8; ch++) begin
            for (int k = 0; k < DB; k++) begin
                if (~pin_q[SYNC-1+k][ch] == m_stable[ch]) m_flip[ch] = 1'b0;
            end
        end
        m_stable_nxt = m_stable ^ m_flip;
        m_cap_set = (m_stable_nxt & ~m_stable & m_rise_en) | (~m_stable_nxt & m_stable & m_fall_en);
        m_cap_clr = (avs_write && avs_address == REG_EDGE_CAP) ? avs_writedata[7:0] : 8'h00;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < HIST; k++) pin_q[k] <= 8'hFF;
            m_stable   <= 8'h00;
            m_data_out <= 8'h00;
            m_mask     <= 8'h00;
            m_cap      <= 8'h00;
            m_rise_en  <= 8'h00;
            m_fall_en  <= 8'h00;
            m_irq      <= 1'b0;
            m_rdata    <= 32'h0;
        end else begin
            pin_q[0] <= pio_in;
            for (int k = 1; k < HIST; k++) pin_q[k] <= pin_q[k-1];
            m_stable <= m_stable_nxt;
            m_cap    <= (m_cap & ~m_cap_clr) | m_cap_set;
            m_irq    <= |(m_cap & m_mask);
            if (avs_read) begin
                case (avs_address)
                    3'd0:    m_rdata <= {24'h0, m_stable};
                    3'd1:    m_rdata <= {24'h0, m_data_out};
                    3'd2:    m_rdata <= {24'h0, m_mask};
                    3'd3:    m_rdata <= {24'h0, m_cap};
                    3'd4:    m_rdata <= {24'h0, m_rise_en};
                    3'd5:    m_rdata <= {24'h0, m_fall_en};
                    default: m_rdata <= 32'h0;
                endcase
            end
            if (avs_write) begin
                case (avs_address)
                    3'd1:    m_data_out <= avs_writedata[7:0];
                    3'd2:    m_mask     <= avs_writedata[7:0];
                    3'd4:    m_rise_en  <= avs_writedata[7:0];
                    3'd5:    m_fall_en  <= avs_writedata[7:0];
                    3'd6:    m_data_out <= m_data_out | avs_writedata[7:0];
                    3'd7:    m_data_out <= m_data_out & ~avs_writedata[7:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check_output("model_pio_out", {24'h0, pio_out}, {24'h0, ~m_data_out});
            check_output("model_irq", {31'h0, irq}, {31'h0, m_irq});
            check_output("model_readdata", avs_readdata, m_rdata);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [2:0] addr, input logic [31:0] data);
        avs_address   = addr;
        avs_writedata = data;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_write     = 1'b0;
    endtask

    task automatic read_reg(input logic [2:0] addr, output logic [31:0] data);
        avs_address = addr;
        avs_read    = 1'b1;
        @(negedge clk);
        avs_read    = 1'b0;
        data        = avs_readdata;
    endtask

    // Holds a continuous DATA_IN read and returns the cycle count until the bit reads 1.
    task automatic measure_data_in(input int bitn, output int n_rd);
        n_rd        = 0;
        avs_address = REG_DATA_IN;
        avs_read    = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (n_rd == 0 && avs_readdata[bitn]) n_rd = c;
        end
        avs_read = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        int          n_rd, n_irq;

        reset_n       = 1'b0;
        avs_address   = 3'd0;
        avs_read      = 1'b0;
        avs_write     = 1'b0;
        avs_writedata = 32'h0;
        pio_in        = 8'hFF;
        tick(1);
        cmp_en = 1'b1;
        tick(2);
        check_output("reset_pio_out", {24'h0, pio_out}, 32'hFF);
        check_output("reset_irq", {31'h0, irq}, 32'h0);
        check_output("reset_readdata", avs_readdata, 32'h0);
        reset_n = 1'b1;
        tick(2);

        apply_stimulus(REG_DATA_OUT, 32'h05);
        check_output("pio_out_polarity", {24'h0, pio_out}, 32'hFA);

        // Three-cycle glitch must be rejected
        pio_in[0] = 1'b0;
        tick(3);
        pio_in[0] = 1'b1;
        tick(10);
        read_reg(REG_DATA_IN, rd);
        check_output("glitch_data_in", rd, 32'h0);

        apply_stimulus(REG_RISE_EN, 32'h1);
        apply_stimulus(REG_IRQ_MASK, 32'h1);
        pio_in[0] = 1'b0;
        n_rd  = 0;
        n_irq = 0;
        avs_address = REG_DATA_IN;
        avs_read    = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (n_rd == 0 && avs_readdata[0]) n_rd = c;
            if (n_irq == 0 && irq) n_irq = c;
        end
        avs_read = 1'b0;
        // stable flips SYNC+DB edges after the pin; the registered read and irq add one
        check_output("data_in_latency", n_rd, SYNC + DB + 1);
        check_output("irq_latency", n_irq, SYNC + DB + 1);
        read_reg(REG_EDGE_CAP, rd);
        check_output("edge_cap_rise", rd, 32'h1);

        apply_stimulus(REG_EDGE_CAP, 32'h1);
        check_output("irq_hold_after_clear", {31'h0, irq}, 32'h1);
        tick(1);
        check_output("irq_drop_after_clear", {31'h0, irq}, 32'h0);

        pio_in[0] = 1'b1;
        tick(10);
        read_reg(REG_EDGE_CAP, rd);
        check_output("no_fall_capture", rd, 32'h0);

        // Clear lands on the same edge that captures the new press
        pio_in[0] = 1'b0;
        tick(5);
        apply_stimulus(REG_EDGE_CAP, 32'h1);
        read_reg(REG_EDGE_CAP, rd);
        check_output("set_beats_clear", rd, 32'h1);
        apply_stimulus(REG_EDGE_CAP, 32'h1);
        pio_in[0] = 1'b1;
        tick(8);

        apply_stimulus(REG_FALL_EN, 32'h2);
        pio_in[1] = 1'b0;
        tick(8);
        read_reg(REG_EDGE_CAP, rd);
        check_output("ch1_rise_ignored", rd, 32'h0);
        pio_in[1] = 1'b1;
        tick(8);
        read_reg(REG_EDGE_CAP, rd);
        check_output("ch1_fall_captured", rd, 32'h2);
        check_output("masked_irq", {31'h0, irq}, 32'h0);
        apply_stimulus(REG_EDGE_CAP, 32'h2);

        apply_stimulus(REG_DATA_OUT, 32'hF0);
        apply_stimulus(REG_OUT_SET, 32'h0F);
        read_reg(REG_DATA_OUT, rd);
        check_output("out_set", rd, 32'hFF);
        apply_stimulus(REG_OUT_CLR, 32'h81);
        read_reg(REG_DATA_OUT, rd);
        check_output("out_clr", rd, 32'h7E);
        check_output("out_clr_pins", {24'h0, pio_out}, 32'h81);
        read_reg(REG_OUT_SET, rd);
        check_output("read_out_set_zero", rd, 32'h0);

        avs_address   = REG_DATA_OUT;
        avs_writedata = 32'h33;
        avs_read      = 1'b1;
        avs_write     = 1'b1;
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        check_output("read_write_pre_value", avs_readdata, 32'h7E);
        read_reg(REG_DATA_OUT, rd);
        check_output("read_write_new_value", rd, 32'h33);

        apply_stimulus(REG_DATA_OUT, 32'hFFFF_FF00);
        read_reg(REG_DATA_OUT, rd);
        check_output("wide_write_ignored", rd, 32'h0);

        // Reset mid-debounce
        apply_stimulus(REG_RISE_EN, 32'hFF);
        apply_stimulus(REG_IRQ_MASK, 32'hFF);
        pio_in[3] = 1'b0;
        tick(8);
        check_output("irq_before_reset", {31'h0, irq}, 32'h1);
        pio_in[2] = 1'b0;
        tick(4);
        reset_n = 1'b0;
        #1;
        check_output("async_reset_irq", {31'h0, irq}, 32'h0);
        check_output("async_reset_pio_out", {24'h0, pio_out}, 32'hFF);
        tick(2);
        reset_n = 1'b1;
        measure_data_in(2, n_rd);
        check_output("post_reset_latency", n_rd, SYNC + DB + 1);
        read_reg(REG_EDGE_CAP, rd);
        check_output("power_up_edge_uncaptured", rd, 32'h0);
        read_reg(REG_DATA_IN, rd);
        check_output("post_reset_data_in", rd, 32'h0C);

        pio_in = 8'hFF;
        tick(10);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
